// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage buffers: data width, NOP word,
// IF/ID buffer state encoding and MIPS instruction field positions.
package pipe_pkg;

    localparam int unsigned DW       = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int unsigned STAT_W   = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int unsigned OP_HI = 31;
    localparam int unsigned OP_LO = 26;
    localparam int unsigned RS_HI = 25;
    localparam int unsigned RS_LO = 21;
    localparam int unsigned RT_HI = 20;
    localparam int unsigned RT_LO = 16;
    localparam int unsigned RD_HI = 15;
    localparam int unsigned RD_LO = 11;
    localparam int unsigned FN_HI = 5;
    localparam int unsigned FN_LO = 0;

endpackage

// File: rtl/ifid_entry.sv
// One IF/ID buffer slot: inst/pc/npc registers with load enable and sync clear.
module ifid_entry
    import pipe_pkg::*;
#(
    parameter int unsigned W = DW
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] inst_i,
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] npc_i,
    output logic [W-1:0] inst_o,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] npc_o
);

    logic [W-1:0] inst_q;
    logic [W-1:0] pc_q;
    logic [W-1:0] npc_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            inst_q <= '0;
            pc_q   <= '0;
            npc_q  <= '0;
        end else if (ld_i) begin
            inst_q <= inst_i;
            pc_q   <= pc_i;
            npc_q  <= npc_i;
        end
    end

    assign inst_o = inst_q;
    assign pc_o   = pc_q;
    assign npc_o  = npc_q;

endmodule

// File: rtl/pipe_ifid_buf.sv
// IF/ID boundary: 2-entry skid buffer with valid/ready on both sides and flush.
// Optional IFID_STATS_EN adds saturating bubble/stall counters.
module pipe_ifid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned    DW       = pipe_pkg::DW,
    parameter logic [DW-1:0]  NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [DW-1:0] if_inst,
    input  logic [DW-1:0] if_pc,
    input  logic [DW-1:0] if_npc,
    input  logic          flush,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [DW-1:0] id_inst,
    output logic [DW-1:0] id_pc,
    output logic [DW-1:0] id_npc,
    output logic [5:0]    id_op,
    output logic [4:0]    id_rs,
    output logic [4:0]    id_rt,
    output logic [4:0]    id_rd,
    output logic [5:0]    id_func
`ifdef IFID_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_bubble,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    state_e        state_q, state_d;
    logic          in_c, out_c;
    logic          main_ld, main_from_skid, skid_ld, skid_clr;
    logic [DW-1:0] main_inst, main_pc, main_npc;
    logic [DW-1:0] skid_inst, skid_pc, skid_npc;
    logic [DW-1:0] main_inst_d, main_pc_d, main_npc_d;

    // Both handshake flags are decodes of the state register only.
    assign if_ready = (state_q != ST_FULL);
    assign id_valid = (state_q != ST_EMPTY);
    assign in_c     = if_valid & if_ready;
    assign out_c    = id_valid & id_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_c) begin
                        main_ld = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_c && out_c) begin
                        main_ld = 1'b1;
                    end else if (in_c) begin
                        skid_ld = 1'b1;
                        state_d = ST_FULL;
                    end else if (out_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_c) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_inst_d = main_from_skid ? skid_inst : if_inst;
    assign main_pc_d   = main_from_skid ? skid_pc   : if_pc;
    assign main_npc_d  = main_from_skid ? skid_npc  : if_npc;

    // Main keeps its contents across flush so id_pc/id_npc hold their last values.
    ifid_entry #(.W(DW)) u_main (
        .clk    (clk),
        .clr_i  (rst),
        .ld_i   (main_ld),
        .inst_i (main_inst_d),
        .pc_i   (main_pc_d),
        .npc_i  (main_npc_d),
        .inst_o (main_inst),
        .pc_o   (main_pc),
        .npc_o  (main_npc)
    );

    ifid_entry #(.W(DW)) u_skid (
        .clk    (clk),
        .clr_i  (rst | skid_clr),
        .ld_i   (skid_ld),
        .inst_i (if_inst),
        .pc_i   (if_pc),
        .npc_i  (if_npc),
        .inst_o (skid_inst),
        .pc_o   (skid_pc),
        .npc_o  (skid_npc)
    );

    assign id_inst = id_valid ? main_inst : NOP_INST;
    assign id_pc   = main_pc;
    assign id_npc  = main_npc;
    assign id_op   = id_inst[OP_HI:OP_LO];
    assign id_rs   = id_inst[RS_HI:RS_LO];
    assign id_rt   = id_inst[RT_HI:RT_LO];
    assign id_rd   = id_inst[RD_HI:RD_LO];
    assign id_func = id_inst[FN_HI:FN_LO];

`ifdef IFID_STATS_EN
    logic [STAT_W-1:0] bubble_q, stall_q;

    // Saturating counters; flush deliberately has no effect on them.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            if (id_ready && !id_valid && (bubble_q != '1)) bubble_q <= bubble_q + STAT_W'(1);
            if (if_valid && !if_ready && (stall_q != '1))  stall_q  <= stall_q + STAT_W'(1);
        end
    end

    assign stat_bubble = bubble_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_pipe_ifid_buf.sv
// Self-checking bench for pipe_ifid_buf against a queue-based reference model.
module tb_pipe_ifid_buf;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, id_ready;
    logic        if_ready, id_valid;
    logic [31:0] if_inst, if_pc, if_npc;
    logic [31:0] id_inst, id_pc, id_npc;
    logic [5:0]  id_op, id_func;
    logic [4:0]  id_rs, id_rt, id_rd;
`ifdef IFID_STATS_EN
    logic [31:0] stat_bubble, stat_stall;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ent_t        mq[$];
    logic [31:0] m_pc, m_npc;
    logic [31:0] m_bubble, m_stall;

    always #5 clk = ~clk;

    pipe_ifid_buf dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .if_npc   (if_npc),
        .flush    (flush),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .id_npc   (id_npc),
        .id_op    (id_op),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .id_func  (id_func)
`ifdef IFID_STATS_EN
        ,
        .stat_bubble (stat_bubble),
        .stat_stall  (stat_stall)
`endif
    );

    function automatic logic m_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic [31:0] m_inst();
        return (mq.size() > 0) ? mq[0].inst : 32'h0;
    endfunction

    // Advance one clock; the model is a FIFO of at most two words.
    task automatic tick();
        bit   acc, con;
        ent_t e;
        @(posedge clk);
        acc = if_valid && (mq.size() < 2);
        con = id_ready && (mq.size() > 0);
        if (id_ready && mq.size() == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
        if (if_valid && mq.size() == 2 && m_stall != 32'hFFFF_FFFF)  m_stall++;
        if (rst) begin
            mq.delete();
            m_pc = 0; m_npc = 0; m_bubble = 0; m_stall = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) begin
                e.inst = if_inst; e.pc = if_pc; e.npc = if_npc;
                mq.push_back(e);
            end
        end
        if (mq.size() > 0) begin
            m_pc  = mq[0].pc;
            m_npc = mq[0].npc;
        end
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid = v; if_pc = pc; if_npc = pc + 32'd4; if_inst = inst;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        present(1'b0, 32'h0, 32'h0);
        tick(); tick();
        n_vec++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_inst !== 32'h0 ||
            id_pc !== 32'h0 || id_npc !== 32'h0) begin
            n_err++;
            $display("FAIL reset: valid=%b ready=%b inst=%h pc=%h npc=%h required 0 1 0 0 0",
                     id_valid, if_ready, id_inst, id_pc, id_npc);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] inst;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst = 32'hA000_0000 | 32'(i) | (32'(i) << 11);
            present(1'b1, 32'(4 * i), inst);
            tick();
            n_vec++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_inst !== inst ||
                id_npc !== 32'(4 * i + 4) || if_ready !== 1'b1 || id_rd !== 5'(i)) begin
                n_err++;
                $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h npc=%h ready=%b rd=%0d required pc=%h inst=%h",
                         i, id_valid, id_pc, id_inst, id_npc, if_ready, id_rd, 4 * i, inst);
            end
        end
        present(1'b0, 32'h0, 32'h0);
        tick();
        n_vec++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'hC || id_npc !== 32'h10) begin
            n_err++;
            $display("FAIL stream_drain: valid=%b inst=%h pc=%h npc=%h required 0 0 c 10",
                     id_valid, id_inst, id_pc, id_npc);
        end
    endtask

    task automatic test_stall_fill();
        id_ready = 1'b0;
        present(1'b1, 32'h0, 32'hB000_0000);
        tick();
        present(1'b1, 32'h4, 32'hB000_0004);
        tick();
        n_vec++;
        if (if_ready !== 1'b0 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_full: ready=%b pc=%h valid=%b required 0 0 1", if_ready, id_pc, id_valid);
        end
        present(1'b1, 32'h8, 32'hB000_0008);
        tick();
        n_vec++;
        if (if_ready !== 1'b0 || id_pc !== 32'h0) begin
            n_err++;
            $display("FAIL stall_hold: ready=%b pc=%h required 0 0", if_ready, id_pc);
        end
        id_ready = 1'b1;
        tick();
        n_vec++;
        if (id_pc !== 32'h4 || id_inst !== 32'hB000_0004 || if_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_rel1: pc=%h inst=%h ready=%b required 4 b0000004 1", id_pc, id_inst, if_ready);
        end
        tick();
        present(1'b0, 32'h0, 32'h0);
        n_vec++;
        if (id_pc !== 32'h8 || id_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_rel2: pc=%h valid=%b required 8 1", id_pc, id_valid);
        end
        tick();
        n_vec++;
        if (id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_drain: valid=%b required 0", id_valid);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        present(1'b1, 32'h10, 32'hC000_0010);
        tick();
        present(1'b1, 32'h14, 32'hC000_0014);
        tick();
        present(1'b1, 32'h18, 32'hC000_0018);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0 || if_ready !== 1'b1 || id_pc !== 32'h10) begin
            n_err++;
            $display("FAIL flush: valid=%b inst=%h ready=%b pc=%h required 0 0 1 10",
                     id_valid, id_inst, if_ready, id_pc);
        end
        id_ready = 1'b1;
        present(1'b1, 32'h40, 32'hC000_0040);
        tick();
        present(1'b0, 32'h0, 32'h0);
        n_vec++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== 32'hC000_0040) begin
            n_err++;
            $display("FAIL flush_next: valid=%b pc=%h inst=%h required 1 40 c0000040", id_valid, id_pc, id_inst);
        end
        tick();
        n_vec++;
        if (id_valid !== 1'b0 || id_pc !== 32'h40) begin
            n_err++;
            $display("FAIL flush_drain: valid=%b pc=%h required 0 40 (0x18 must not appear)", id_valid, id_pc);
        end
    endtask

    task automatic test_simul_in_out();
        id_ready = 1'b0;
        present(1'b1, 32'h20, 32'hD000_0020);
        tick();
        id_ready = 1'b1;
        present(1'b1, 32'h24, 32'hD000_0024);
        tick();
        present(1'b0, 32'h0, 32'h0);
        n_vec++;
        if (id_pc !== 32'h24 || id_valid !== 1'b1 || if_ready !== 1'b1) begin
            n_err++;
            $display("FAIL simul: pc=%h valid=%b ready=%b required 24 1 1", id_pc, id_valid, if_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        id_ready = 1'b0;
        present(1'b1, 32'h30, 32'hE000_0030);
        tick();
        present(1'b1, 32'h34, 32'hE000_0034);
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        present(1'b0, 32'h0, 32'h0);
        n_vec++;
        if (id_pc !== 32'h0 || id_npc !== 32'h0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: pc=%h npc=%h valid=%b ready=%b required 0 0 0 1",
                     id_pc, id_npc, id_valid, if_ready);
        end
`ifdef IFID_STATS_EN
        n_vec++;
        if (stat_bubble !== 32'h0 || stat_stall !== 32'h0) begin
            n_err++;
            $display("FAIL reset_stats: bubble=%0d stall=%0d required 0 0", stat_bubble, stat_stall);
        end
`endif
    endtask

`ifdef IFID_STATS_EN
    task automatic test_stats();
        id_ready = 1'b1;
        present(1'b0, 32'h0, 32'h0);
        repeat (5) tick();
        id_ready = 1'b0;
        present(1'b1, 32'h50, 32'hF000_0050);
        tick();
        present(1'b1, 32'h54, 32'hF000_0054);
        tick();
        present(1'b1, 32'h58, 32'hF000_0058);
        repeat (3) tick();
        present(1'b0, 32'h0, 32'h0);
        n_vec++;
        if (stat_bubble !== 32'd5 || stat_stall !== 32'd3) begin
            n_err++;
            $display("FAIL stats: bubble=%0d stall=%0d required 5 3", stat_bubble, stat_stall);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (stat_bubble !== 32'd5 || stat_stall !== 32'd3) begin
            n_err++;
            $display("FAIL stats_flush: bubble=%0d stall=%0d required 5 3", stat_bubble, stat_stall);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] ei;
        for (int i = 0; i < 400; i++) begin
            if_valid = ($urandom_range(0, 9) < 7);
            id_ready = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            if_inst  = $urandom;
            if_pc    = $urandom;
            if_npc   = $urandom;
            tick();
            ei = m_inst();
            n_vec++;
            if (id_valid !== m_valid() || if_ready !== (mq.size() < 2) || id_inst !== ei ||
                id_pc !== m_pc || id_npc !== m_npc) begin
                n_err++;
                $display("FAIL rand[%0d]: valid=%b ready=%b inst=%h pc=%h npc=%h required %b %b %h %h %h",
                         i, id_valid, if_ready, id_inst, id_pc, id_npc,
                         m_valid(), mq.size() < 2, ei, m_pc, m_npc);
            end
            n_vec++;
            if (id_op !== ei[31:26] || id_rs !== ei[25:21] || id_rt !== ei[20:16] ||
                id_rd !== ei[15:11] || id_func !== ei[5:0]) begin
                n_err++;
                $display("FAIL rand_fields[%0d]: op=%h rs=%h rt=%h rd=%h fn=%h from inst %h",
                         i, id_op, id_rs, id_rt, id_rd, id_func, ei);
            end
`ifdef IFID_STATS_EN
            n_vec++;
            if (stat_bubble !== m_bubble || stat_stall !== m_stall) begin
                n_err++;
                $display("FAIL rand_stats[%0d]: bubble=%0d stall=%0d required %0d %0d",
                         i, stat_bubble, stat_stall, m_bubble, m_stall);
            end
`endif
        end
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
    endtask

    initial begin
        m_pc = 0; m_npc = 0; m_bubble = 0; m_stall = 0;
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        present(1'b0, 32'h0, 32'h0);
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush();
        test_simul_in_out();
        test_reset_mid();
`ifdef IFID_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
